// File: rtl/lane_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lane_adder_pkg
// Purpose  : Shared constants, mode encodings and lane-slice helper for the
//            lane_adder_array datapath.
// Revision : 1.0 - initial release
// ============================================================================
package lane_adder_pkg;

    localparam int LA_DEF_WIDTH = 8;
    localparam int LA_DEF_LANES = 2;

    localparam int LA_MODE_ADD = 0;
    localparam int LA_MODE_ACC = 1;

    // Base bit of lane 'lane' in a packed bus of 'width'-bit lanes; use as [base +: width].
    function automatic int la_lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lane_adder_stage.sv
`default_nettype none
// ============================================================================
// Module   : lane_adder_stage
// Purpose  : One lane of the S2 register: adder, optional accumulator and
//            saturation. Saturation is enabled by LANE_ADDER_ARRAY_SAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module lane_adder_stage
    import lane_adder_pkg::*;
#(
    parameter int WIDTH = LA_DEF_WIDTH,
    parameter int ACCUM = LA_MODE_ADD
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

`ifdef LANE_ADDER_ARRAY_SAT_EN
    localparam bit c_sat_en = 1'b1;
`else
    localparam bit c_sat_en = 1'b0;
`endif
    localparam logic [WIDTH-1:0] c_sat_max = '1;

    logic [WIDTH-1:0] w_sum_next;
    logic             w_ovf;

    generate
        if (ACCUM == LA_MODE_ACC) begin : g_accum
            logic [WIDTH-1:0] r_acc;
            logic [WIDTH+1:0] w_full;

            // clear takes priority over the old accumulator value for a loading beat
            assign w_full     = (clear ? '0 : {2'b00, r_acc}) + {2'b00, a} + {2'b00, b};
            assign w_ovf      = |w_full[WIDTH+1:WIDTH];
            assign w_sum_next = (c_sat_en && w_ovf) ? c_sat_max : w_full[WIDTH-1:0];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_acc <= '0;
                end else if (load) begin
                    r_acc <= w_sum_next;
                end else if (clear) begin
                    r_acc <= '0;
                end
            end
        end else begin : g_add
            logic [WIDTH:0] w_full;
            logic           w_unused_clear;

            assign w_unused_clear = clear;
            assign w_full         = {1'b0, a} + {1'b0, b};
            assign w_ovf          = w_full[WIDTH];
            assign w_sum_next     = (c_sat_en && w_ovf) ? c_sat_max : w_full[WIDTH-1:0];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum   <= '0;
            carry <= 1'b0;
        end else if (load) begin
            sum   <= w_sum_next;
            carry <= w_ovf;
        end
    end

endmodule
`default_nettype wire

// File: rtl/lane_adder_array.sv
`default_nettype none
// ============================================================================
// Module   : lane_adder_array
// Purpose  : LANES x WIDTH registered adder behind a two-stage valid/ready
//            pipeline. Optional saturation: LANE_ADDER_ARRAY_SAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module lane_adder_array
    import lane_adder_pkg::*;
#(
    parameter int WIDTH = LA_DEF_WIDTH,
    parameter int LANES = LA_DEF_LANES,
    parameter int ACCUM = LA_MODE_ADD
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] a,
    input  logic [LANES*WIDTH-1:0] b,
    input  logic                   clear,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] sum,
    output logic [LANES-1:0]       carry
);

    logic                   r_s1_valid;
    logic [LANES*WIDTH-1:0] r_s1_a;
    logic [LANES*WIDTH-1:0] r_s1_b;
    logic                   r_s2_valid;
    logic                   w_s1_load;
    logic                   w_s2_load;

    assign w_s2_load = r_s1_valid && (!r_s2_valid || out_ready);
    // Held low during reset so the producer never sees a ready that cannot be honoured
    assign in_ready  = rst_n && (!r_s1_valid || w_s2_load);
    assign w_s1_load = in_valid && in_ready;
    assign out_valid = r_s2_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s2_valid <= 1'b0;
        end else begin
            if (w_s1_load) begin
                r_s1_valid <= 1'b1;
                r_s1_a     <= a;
                r_s1_b     <= b;
            end else if (w_s2_load) begin
                r_s1_valid <= 1'b0;
            end

            if (w_s2_load) begin
                r_s2_valid <= 1'b1;
            end else if (out_ready) begin
                r_s2_valid <= 1'b0;
            end
        end
    end

    generate
        for (genvar i = 0; i < LANES; i++) begin : lane_gen
            lane_adder_stage #(
                .WIDTH (WIDTH),
                .ACCUM (ACCUM)
            ) u_lane (
                .clk   (clk),
                .rst_n (rst_n),
                .load  (w_s2_load),
                .clear (clear),
                .a     (r_s1_a[la_lane_lsb(i, WIDTH) +: WIDTH]),
                .b     (r_s1_b[la_lane_lsb(i, WIDTH) +: WIDTH]),
                .sum   (sum[la_lane_lsb(i, WIDTH) +: WIDTH]),
                .carry (carry[i])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_lane_adder_array.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_lane_adder_array
// Purpose  : Scoreboard bench for lane_adder_array: an 8x2 add instance and a
//            16x4 accumulate instance against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lane_adder_array;

    localparam int AW = 8;
    localparam int AL = 2;
    localparam int BW = 16;
    localparam int BL = 4;
`ifdef LANE_ADDER_ARRAY_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              a_in_valid  = 1'b0;
    logic              a_in_ready;
    logic              a_clear     = 1'b0;
    logic              a_out_valid;
    logic              a_out_ready = 1'b1;
    logic [AL*AW-1:0]  a_a = '0;
    logic [AL*AW-1:0]  a_b = '0;
    logic [AL*AW-1:0]  a_sum;
    logic [AL-1:0]     a_carry;

    logic              b_in_valid  = 1'b0;
    logic              b_in_ready;
    logic              b_clear     = 1'b0;
    logic              b_out_valid;
    logic              b_out_ready = 1'b1;
    logic [BL*BW-1:0]  b_a = '0;
    logic [BL*BW-1:0]  b_b = '0;
    logic [BL*BW-1:0]  b_sum;
    logic [BL-1:0]     b_carry;

    lane_adder_array #(.WIDTH(AW), .LANES(AL), .ACCUM(0)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .a(a_a), .b(a_b), .clear(a_clear), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .sum(a_sum), .carry(a_carry)
    );

    lane_adder_array #(.WIDTH(BW), .LANES(BL), .ACCUM(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .a(b_a), .b(b_b), .clear(b_clear), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .sum(b_sum), .carry(b_carry)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [AL*AW+AL-1:0] q_a[$];
    logic [BL*BW+BL-1:0] q_b[$];
    logic [AL*AW+AL-1:0] exp_a;
    logic [BL*BW+BL-1:0] exp_b;
    longint acc_b[BL];
    bit a_done;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: each lane is an independent integer sum, carry = result exceeds lane range
    function automatic logic [AL*AW+AL-1:0] model_a(input logic [AL*AW-1:0] x, input logic [AL*AW-1:0] y);
        logic [AL*AW-1:0] s;
        logic [AL-1:0]    c;
        longint lim;
        longint full;
        lim = longint'(1) << AW;
        for (int l = 0; l < AL; l++) begin
            full = longint'(x[l*AW +: AW]) + longint'(y[l*AW +: AW]);
            c[l] = (full >= lim);
            if (c[l]) full = SAT ? lim - 1 : full % lim;
            s[l*AW +: AW] = full[AW-1:0];
        end
        return {c, s};
    endfunction

    function automatic logic [BL*BW+BL-1:0] model_b(input logic [BL*BW-1:0] x, input logic [BL*BW-1:0] y, input bit clr);
        logic [BL*BW-1:0] s;
        logic [BL-1:0]    c;
        longint lim;
        longint full;
        lim = longint'(1) << BW;
        for (int l = 0; l < BL; l++) begin
            if (clr) acc_b[l] = 0;
            full = acc_b[l] + longint'(x[l*BW +: BW]) + longint'(y[l*BW +: BW]);
            c[l] = (full >= lim);
            if (c[l]) full = SAT ? lim - 1 : full % lim;
            acc_b[l] = full;
            s[l*BW +: BW] = full[BW-1:0];
        end
        return {c, s};
    endfunction

    always @(negedge clk) begin
        if (rst_n && a_out_valid && a_out_ready) begin
            if (q_a.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL a_unexpected: got %0h expected no beat", {a_carry, a_sum});
            end else begin
                exp_a = q_a.pop_front();
                check("a_result", 128'({a_carry, a_sum}), 128'(exp_a));
            end
        end
        if (rst_n && b_out_valid && b_out_ready) begin
            if (q_b.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL b_unexpected: got %0h expected no beat", {b_carry, b_sum});
            end else begin
                exp_b = q_b.pop_front();
                check("b_result", 128'({b_carry, b_sum}), 128'(exp_b));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send_a(input logic [AL*AW-1:0] x, input logic [AL*AW-1:0] y);
        int guard = 0;
        a_a = x; a_b = y; a_in_valid = 1'b1;
        @(negedge clk);
        while (!a_in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!a_in_ready) begin
            n_cmp++; n_err++;
            $display("FAIL a_send_timeout: in_ready=0 expected 1");
        end else begin
            q_a.push_back(model_a(x, y));
        end
        @(posedge clk); #1;
        a_in_valid = 1'b0;
    endtask

    // clear for a beat is driven in the cycle its S2 load happens (one after acceptance).
    task automatic send_b(input logic [BL*BW-1:0] x, input logic [BL*BW-1:0] y, input bit clr);
        b_a = x; b_b = y; b_in_valid = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (!b_in_ready) begin
            n_err++;
            $display("FAIL b_in_ready: got 0 expected 1");
        end else begin
            q_b.push_back(model_b(x, y, clr));
        end
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        b_clear    = clr;
    endtask

    task automatic idle_b();
        @(posedge clk); #1;
        b_clear = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && guard < 500) begin
            @(posedge clk);
            guard++;
        end
        n_cmp++;
        if (q_a.size() + q_b.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d beats outstanding expected 0", q_a.size() + q_b.size());
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [AL*AW-1:0] held_sum;
    logic [AL-1:0]    held_carry;

    initial begin
        for (int l = 0; l < BL; l++) acc_b[l] = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_a_in_ready",  128'(a_in_ready), 128'(0));
        check("rst_a_out_valid", 128'(a_out_valid), 128'(0));
        check("rst_a_sum",       128'({a_carry, a_sum}), 128'(0));
        check("rst_b_sum",       128'({b_carry, b_sum, b_out_valid}), 128'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_a_in_ready", 128'(a_in_ready), 128'(1));
        check("post_rst_b_in_ready", 128'(b_in_ready), 128'(1));
        @(posedge clk); #1;

        // Latency: accepted at edge N, out_valid visible only after edge N+1
        send_a({8'd100, 8'd100}, {8'd50, 8'd50});
        @(negedge clk);
        check("latency_edge_n", 128'(a_out_valid), 128'(0));
        @(negedge clk);
        check("latency_edge_n1", 128'(a_out_valid), 128'(1));
        @(posedge clk); #1;

        send_a({8'd200, 8'd7}, {8'd100, 8'd9});
        send_a({8'd255, 8'd0}, {8'd255, 8'd0});
        drain();

        // Backpressure: two beats fill the pipe, then in_ready must drop
        a_out_ready = 1'b0;
        send_a({8'd1, 8'd2}, {8'd3, 8'd4});
        send_a({8'd5, 8'd6}, {8'd7, 8'd8});
        a_a = {8'd9, 8'd10}; a_b = {8'd11, 8'd12}; a_in_valid = 1'b1;
        @(negedge clk);
        check("bp_in_ready", 128'(a_in_ready), 128'(0));
        check("bp_out_valid", 128'(a_out_valid), 128'(1));
        held_sum = a_sum; held_carry = a_carry;
        @(negedge clk);
        check("bp_sum_stable", 128'({a_carry, a_sum}), 128'({held_carry, held_sum}));
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        a_out_ready = 1'b1;
        send_a({8'd9, 8'd10}, {8'd11, 8'd12});
        send_a({8'd130, 8'd140}, {8'd150, 8'd160});
        send_a({8'd13, 8'd14}, {8'd15, 8'd16});
        drain();

        // Random traffic with random backpressure
        a_done = 1'b0;
        fork
            begin
                for (int k = 0; k < 60; k++) send_a((AL*AW)'($urandom), (AL*AW)'($urandom));
                a_done = 1'b1;
            end
            begin
                while (!a_done) begin
                    @(posedge clk); #1;
                    a_out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        a_out_ready = 1'b1;
        drain();

        // Accumulate: 3, 10, 15, then clear with (7,1) gives 8
        send_b({48'd0, 16'd1}, {48'd0, 16'd2}, 1'b0);
        send_b({48'd0, 16'd3}, {48'd0, 16'd4}, 1'b0);
        send_b({48'd0, 16'd5}, {48'd0, 16'd0}, 1'b0);
        send_b({48'd0, 16'd7}, {48'd0, 16'd1}, 1'b1);
        send_b({16'd65535, 16'd30, 16'd20, 16'd10}, {16'd1, 16'd3, 16'd2, 16'd1}, 1'b1);
        idle_b();
        drain();

        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 3) == 0) idle_b();
            else send_b({$urandom, $urandom}, {$urandom, $urandom}, ($urandom_range(0, 7) == 0));
        end
        idle_b();
        drain();

        // Asynchronous reset with two beats in flight
        a_out_ready = 1'b0;
        send_a({8'd21, 8'd22}, {8'd23, 8'd24});
        send_a({8'd25, 8'd26}, {8'd27, 8'd28});
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_out_valid", 128'(a_out_valid), 128'(0));
        check("rst_async_in_ready",  128'(a_in_ready), 128'(0));
        q_a.delete();
        for (int l = 0; l < BL; l++) acc_b[l] = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        a_out_ready = 1'b1;
        send_a({8'd9, 8'd9}, {8'd9, 8'd9});
        send_b({48'd0, 16'd4}, {48'd0, 16'd5}, 1'b0);
        idle_b();
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lane_adder_array.md
# lane_adder_array

Parametrised multi-lane registered adder. It generalises the single-width combinational adder into LANES independent WIDTH-bit lanes behind a two-stage valid/ready pipeline, with an optional per-lane accumulate mode. It sits between an operand producer and a result consumer in datapath tests. It is also the standard target for per-lane hierarchical parameter overrides inside generate loops.

## Interface
- WIDTH, 8: operand/result width per lane (≥1)
- LANES, 2: number of independent lanes (≥1)
- ACCUM, 0: 0 = each result is a+b; 1 = each lane keeps a running accumulator acc += a+b
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous and active-low
- in_valid  in  1  operand beat valid
- in_ready  out  1  array can accept an operand beat
- a  in  LANES*WIDTH  lane i operand A at [i*WIDTH +: WIDTH]
- b  in  LANES*WIDTH  lane i operand B, same packing
- clear  in  1  zero all accumulators (ACCUM=1 only; ignored when ACCUM=0)
- out_valid  out  1  result beat valid
- out_ready  in  1  consumer accepts result beat
- sum  out  LANES*WIDTH  lane results, same packing as a
- carry  out  LANES  per-lane carry-out/overflow of the add that produced sum

## Operation
- Transfer occurs on a rising edge where valid && ready, on both the input and output sides. All lanes move together as one beat; there is no per-lane handshake.
- Stage 1 (S1) registers a and b. Stage 2 (S2) registers sum and carry.
- S2 loads when S1 is valid and (S2 is empty or out_ready).
- S1 loads when in_valid && in_ready.
- in_ready = !s1_valid || S2 loads this cycle. It is combinational from out_ready.
- Add rule, ACCUM=0: full = {1'b0,a} + {1'b0,b}, computed at WIDTH+1 bits. sum = full[WIDTH-1:0]; carry = full[WIDTH].
- Add rule, ACCUM=1: full = acc + a + b, computed at WIDTH+2 bits. sum = acc_next = low WIDTH bits; carry = OR of the bits above WIDTH. The accumulator updates only when S2 loads.
- clear:
  - Zeroes every accumulator at the edge where it is high.
  - clear in the same cycle as an S2 load: clear wins for the old value. The loading beat computes with acc = 0, so sum = a+b.
  - clear has no effect on the S1/S2 valid flags.
- Reset mid-operation: all in-flight beats are discarded and no partial beat is ever presented.

## Timing
- Reset values:
  - in_ready = 1 once rst_n is released; it is 0 while rst_n is low.
  - out_valid = 0, sum = 0, carry = 0, all accumulators = 0, s1_valid = 0.
- Latency: an input accepted at edge N appears with out_valid = 1 after edge N+1.
- Throughput: one beat per cycle while out_ready is held at 1.
- Backpressure:
  - With out_ready = 0, the pipe holds 2 beats and then in_ready drops.
  - sum and carry stay stable while out_valid && !out_ready.
- Simultaneous events:
  - A full pipe with out_ready = 1 accepts a new input in the same cycle.
  - Order is strictly preserved; there is no bypass of S1.

## Configuration
- LANE_ADDER_ARRAY_SAT_EN defined:
  - Each lane saturates. When the add overflows, sum is forced to all-ones ({WIDTH{1'b1}}).
  - In ACCUM=1 the accumulator also saturates, and sticks at max until clear.
  - carry still reports that overflow occurred.
- Undefined: modular wrap-around as described in Operation.

## Structure
- Package lane_adder_pkg holds:
  - default constants LA_DEF_WIDTH = 8 and LA_DEF_LANES = 2
  - a function that extracts the lane slice
  - the ACCUM mode encodings (LA_MODE_ADD = 0, LA_MODE_ACC = 1)
- Sub-module lane_adder_stage holds the per-lane S2 adder, accumulator and saturation logic. It is parametrised by WIDTH and ACCUM.
- Instances are made in a generate loop. The hierarchical name is fixed as lane_gen[i].u_lane so that benches can address individual lanes.
- The handshake/valid control is shared and lives in the top module.

## Test plan
- WIDTH=8, LANES=2, ACCUM=0; a = {8'd100, 8'd100}, b = {8'd50, 8'd50} → two cycles later sum = {150, 150}, carry = 2'b00.
- Overflow: a = 200, b = 100.
  - Macro off: sum = 44, carry = 1.
  - Macro on: sum = 255, carry = 1.
- Backpressure:
  - Stream 5 beats with out_ready = 0 → in_ready drops after 2 accepts.
  - Release out_ready → all 5 results appear in order with no loss or duplicates.
- ACCUM=1: beats (1,2), (3,4), (5,0) → sum = 3, 10, 15. Then assert clear with beat (7,1) → sum = 8.
- Reset mid-stream: assert rst_n low with 2 beats in flight → out_valid = 0 immediately (asynchronously). After release, the first new beat (9,9) yields 18 and no stale data appears.
- LANES=4, WIDTH=16 override: lane 3 gets 65535 + 1 → sum = 0, carry = 1; lanes 0–2 are unaffected.
